// File: rtl/fsa_tsi_pkg.sv
// Shared constants and types for the TSI word <-> serial phit width adapter.
// Holds the TSI word width, the TX state encoding and the beats-per-word helper.
package fsa_tsi_pkg;

  localparam int TSI_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  function automatic int beats(input int phit_w);
    return TSI_W / phit_w;
  endfunction

endpackage

// File: rtl/fsa_tsi_deser.sv
// RX gather: packs BEATS LSB-first phits into one word; word valid the cycle after the last phit.
// Holds one word; phit_ready drops while it is full and returns the cycle after the word is taken.
module fsa_tsi_deser
  import fsa_tsi_pkg::*;
#(
  parameter int PHIT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              phit_valid,
  output logic              phit_ready,
  input  logic [PHIT_W-1:0] phit_bits,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [TSI_W-1:0]  word_bits
);

  localparam int BEATS = beats(PHIT_W);
  localparam int CW = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [TSI_W-1:0] rx_shift;
  logic [CW-1:0]    rx_cnt;
  logic             rx_full;
  logic             phit_fire;
  logic             word_fire;

  // Handshake outputs are held low while reset is applied.
  assign phit_ready = !rx_full && !reset;
  assign word_valid = rx_full && !reset;
  assign word_bits  = rx_shift;

  assign phit_fire = phit_valid && phit_ready;
  assign word_fire = word_valid && word_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_shift <= '0;
      rx_cnt   <= '0;
      rx_full  <= 1'b0;
    end else begin
      if (phit_fire) begin
        // New phit enters at the top; after BEATS phits the first one sits at bit 0.
        rx_shift <= (rx_shift >> PHIT_W) | (TSI_W'(phit_bits) << (TSI_W - PHIT_W));
        if (rx_cnt == LAST) begin
          rx_cnt  <= '0;
          rx_full <= 1'b1;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      end
      if (word_fire) begin
        rx_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fsa_tsi_serdes.sv
// 32-bit TSI word <-> PHIT_W-bit serial link adapter; TX first phit 1 cycle after host fire, RX word 1 cycle after last phit.
// Both paths are independent ready/valid pipelines; TX accepts no new word until the current one is fully sent.
module fsa_tsi_serdes
  import fsa_tsi_pkg::*;
#(
  parameter int PHIT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic [TSI_W-1:0]  host_req_bits,
  output logic              host_resp_valid,
  input  logic              host_resp_ready,
  output logic [TSI_W-1:0]  host_resp_bits,
  output logic              ser_out_valid,
  input  logic              ser_out_ready,
  output logic [PHIT_W-1:0] ser_out_bits,
  input  logic              ser_in_valid,
  output logic              ser_in_ready,
  input  logic [PHIT_W-1:0] ser_in_bits
);

  localparam int BEATS = beats(PHIT_W);
  localparam int CW = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if (!(PHIT_W == 1 || PHIT_W == 2 || PHIT_W == 4 ||
        PHIT_W == 8 || PHIT_W == 16 || PHIT_W == 32)) begin : g_bad_phit_w
    $error("fsa_tsi_serdes: PHIT_W must be 1, 2, 4, 8, 16 or 32");
  end

  tx_state_e        state, state_nxt;
  logic [TSI_W-1:0] tx_shift, tx_shift_nxt;
  logic [CW-1:0]    tx_cnt, tx_cnt_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tx_shift <= '0;
      tx_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      tx_shift <= tx_shift_nxt;
      tx_cnt   <= tx_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    tx_shift_nxt   = tx_shift;
    tx_cnt_nxt     = tx_cnt;
    host_req_ready = 1'b0;
    ser_out_valid  = 1'b0;
    case (state)
      IDLE: begin
        host_req_ready = 1'b1;
        if (host_req_valid) begin
          tx_shift_nxt = host_req_bits;
          tx_cnt_nxt   = '0;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        ser_out_valid = 1'b1;
        if (ser_out_ready) begin
          tx_shift_nxt = tx_shift >> PHIT_W;
          tx_cnt_nxt   = tx_cnt + CW'(1);
          if (tx_cnt == LAST) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Register state is overwritten on the clock edge anyway; this keeps the handshakes quiet during reset.
    if (reset) begin
      host_req_ready = 1'b0;
      ser_out_valid  = 1'b0;
    end
  end

  // Phits go out LSB-first from the bottom of the shift register.
  assign ser_out_bits = tx_shift[PHIT_W-1:0];

  fsa_tsi_deser #(
    .PHIT_W(PHIT_W)
  ) u_deser (
    .clock      (clock),
    .reset      (reset),
    .phit_valid (ser_in_valid),
    .phit_ready (ser_in_ready),
    .phit_bits  (ser_in_bits),
    .word_valid (host_resp_valid),
    .word_ready (host_resp_ready),
    .word_bits  (host_resp_bits)
  );

endmodule

// File: tb/tb_fsa_tsi_serdes.sv
// Bench for fsa_tsi_serdes: cycle table on a PHIT_W=8 instance plus random word streams on PHIT_W=1/4/32 instances.
module tb_fsa_tsi_serdes;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed instance, PHIT_W=8 ----------------
  logic        d_rst, d_hv, d_hr, d_hrv, d_hrr, d_sov, d_sor, d_siv, d_sir;
  logic [31:0] d_hb, d_hrb;
  logic [7:0]  d_sob, d_sib;

  fsa_tsi_serdes #(.PHIT_W(8)) dut (
    .clock           (clock),
    .reset           (d_rst),
    .host_req_valid  (d_hv),
    .host_req_ready  (d_hr),
    .host_req_bits   (d_hb),
    .host_resp_valid (d_hrv),
    .host_resp_ready (d_hrr),
    .host_resp_bits  (d_hrb),
    .ser_out_valid   (d_sov),
    .ser_out_ready   (d_sor),
    .ser_out_bits    (d_sob),
    .ser_in_valid    (d_siv),
    .ser_in_ready    (d_sir),
    .ser_in_bits     (d_sib)
  );

  typedef struct {
    logic        rst, hv;
    logic [31:0] hb;
    logic        sor, siv;
    logic [7:0]  sib;
    logic        hrr, cb;
    logic        e_hr, e_sov;
    logic [7:0]  e_sob;
    logic        e_sir, e_hrv;
    logic [31:0] e_hrb;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic hv, input logic [31:0] hb,
                              input logic sor, input logic siv, input logic [7:0] sib,
                              input logic hrr, input logic cb, input logic e_hr,
                              input logic e_sov, input logic [7:0] e_sob, input logic e_sir,
                              input logic e_hrv, input logic [31:0] e_hrb);
    vec_t v;
    v.rst = rst; v.hv = hv; v.hb = hb; v.sor = sor; v.siv = siv; v.sib = sib;
    v.hrr = hrr; v.cb = cb; v.e_hr = e_hr; v.e_sov = e_sov; v.e_sob = e_sob;
    v.e_sir = e_sir; v.e_hrv = e_hrv; v.e_hrb = e_hrb;
    return v;
  endfunction

  // ---------------- random instances, PHIT_W = 1, 4, 32 ----------------
  for (genvar g = 0; g < 3; g++) begin : rnd
    localparam int W  = (g == 0) ? 1 : (g == 1) ? 4 : 32;
    localparam int NB = 32 / W;
    localparam int NW = 1000;

    logic        rst, hv, hr, hrv, hrr, sov, sor, siv, sir;
    logic [31:0] hb, hrb;
    logic [W-1:0] sob, sib;
    bit done = 1'b0;

    fsa_tsi_serdes #(.PHIT_W(W)) dut (
      .clock           (clock),
      .reset           (rst),
      .host_req_valid  (hv),
      .host_req_ready  (hr),
      .host_req_bits   (hb),
      .host_resp_valid (hrv),
      .host_resp_ready (hrr),
      .host_resp_bits  (hrb),
      .ser_out_valid   (sov),
      .ser_out_ready   (sor),
      .ser_out_bits    (sob),
      .ser_in_valid    (siv),
      .ser_in_ready    (sir),
      .ser_in_bits     (sib)
    );

    initial begin
      logic [31:0] txq[$];
      logic [31:0] rxq[$];
      logic [31:0] tx_acc, rx_cur, expw;
      logic [W-1:0] stall_bits;
      int tx_sent, rx_sent, tx_done, rx_done, tx_ph, ri, cyc;
      bit hv_f, so_f, si_f, hr_f, exp_vld, stall, have;
      tx_sent = 0; rx_sent = 0; tx_done = 0; rx_done = 0; tx_ph = 0; ri = 0; cyc = 0;
      tx_acc = '0; rx_cur = '0; stall_bits = '0;
      hv_f = 0; so_f = 0; si_f = 0; hr_f = 0; exp_vld = 0; stall = 0; have = 0;
      rst = 1'b1; hv = 0; hb = '0; sor = 0; siv = 0; sib = '0; hrr = 0;
      repeat (2) @(posedge clock);
      while ((tx_done < NW || rx_done < NW) && cyc < 90000) begin
        @(negedge clock);
        cyc++;
        rst = 1'b0;
        if (hv_f || !hv) begin
          hv = 1'b0;
          if (tx_sent < NW && $urandom_range(0, 3) != 0) begin
            hb = $urandom;
            hv = 1'b1;
            txq.push_back(hb);
            tx_sent++;
          end
        end
        sor = ($urandom_range(0, 7) != 0);
        if (si_f || !siv) begin
          siv = 1'b0;
          if (!have && rx_sent < NW) begin
            rx_cur = $urandom;
            rxq.push_back(rx_cur);
            rx_sent++;
            have = 1'b1;
          end
          if (have && $urandom_range(0, 7) != 0) begin
            siv = 1'b1;
            sib = W'(rx_cur >> (ri * W));
          end
        end
        hrr = ($urandom_range(0, 3) != 0);
        #1;
        if (stall) begin
          chk($sformatf("w%0d tx valid held", W), sov, 1'b1);
          chk($sformatf("w%0d tx bits stable", W), 32'(sob), 32'(stall_bits));
        end
        if (exp_vld) begin
          chk($sformatf("w%0d rx valid latency", W), hrv, 1'b1);
          exp_vld = 0;
        end
        hv_f = hv && hr;
        so_f = sov && sor;
        si_f = siv && sir;
        hr_f = hrv && hrr;
        stall = sov && !sor;
        stall_bits = sob;
        if (so_f) begin
          tx_acc = tx_acc | (32'(sob) << (tx_ph * W));
          tx_ph++;
          if (tx_ph == NB) begin
            expw = (txq.size() > 0) ? txq.pop_front() : ~tx_acc;
            chk($sformatf("w%0d tx word %0d", W, tx_done), tx_acc, expw);
            tx_acc = '0;
            tx_ph = 0;
            tx_done++;
          end
        end
        if (hr_f) begin
          expw = (rxq.size() > 0) ? rxq.pop_front() : ~hrb;
          chk($sformatf("w%0d rx word %0d", W, rx_done), hrb, expw);
          rx_done++;
        end
        if (si_f) begin
          ri++;
          if (ri == NB) begin
            ri = 0;
            have = 1'b0;
            exp_vld = 1'b1;
          end
        end
      end
      chk($sformatf("w%0d tx words delivered", W), tx_done, NW);
      chk($sformatf("w%0d rx words delivered", W), rx_done, NW);
      done = 1'b1;
    end
  end

  // ---------------- directed table + summary ----------------
  initial begin
    vec_t vt[$];
    vec_t v;
    int w;
    // rst hv hb            sor siv sib   hrr cb | hr sov sob   sir hrv hrb
    vt.push_back(mk(1, 0, 32'h0,        0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 32'h0));
    vt.push_back(mk(0, 1, 32'hDEADBEEF, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 0, 1, 8'hEF, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 0, 1, 8'hBE, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 0, 1, 8'hAD, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 0, 1, 8'hDE, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 1, 8'h78, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 1, 8'h56, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 1, 8'h34, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 1, 8'h12, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 1, 8'hFF, 0, 0, 1, 0, 8'h00, 0, 1, 32'h12345678));
    vt.push_back(mk(0, 0, 32'h0,        0, 1, 8'hFF, 0, 0, 1, 0, 8'h00, 0, 1, 32'h12345678));
    vt.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1, 32'h12345678));
    vt.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 1, 32'hA5A5F00F, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 0, 0, 0, 1, 8'h0F, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 0, 1, 8'h0F, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 0, 0, 0, 1, 8'hF0, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 0, 1, 8'hF0, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 1, 8'hAA, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 1, 8'hBB, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(1, 0, 32'h0,        0, 1, 8'hCC, 0, 0, 0, 0, 8'h00, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 32'h0,        0, 1, 8'hCC, 0, 1, 0, 0, 8'h00, 0, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 1, 8'h04, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 1, 8'h03, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 1, 8'h02, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 1, 8'h01, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1, 32'h01020304));
    vt.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0, 32'h0));

    d_rst = 1'b1; d_hv = 0; d_hb = '0; d_sor = 0; d_siv = 0; d_sib = '0; d_hrr = 0;
    repeat (2) @(posedge clock);
    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      @(negedge clock);
      d_rst = v.rst; d_hv = v.hv; d_hb = v.hb; d_sor = v.sor;
      d_siv = v.siv; d_sib = v.sib; d_hrr = v.hrr;
      #1;
      chk($sformatf("row%0d host_req_ready", i), d_hr, v.e_hr);
      chk($sformatf("row%0d ser_out_valid", i), d_sov, v.e_sov);
      chk($sformatf("row%0d ser_in_ready", i), d_sir, v.e_sir);
      chk($sformatf("row%0d host_resp_valid", i), d_hrv, v.e_hrv);
      if (v.e_sov || v.cb) chk($sformatf("row%0d ser_out_bits", i), 32'(d_sob), 32'(v.e_sob));
      if (v.e_hrv || v.cb) chk($sformatf("row%0d host_resp_bits", i), d_hrb, v.e_hrb);
    end

    w = 0;
    while (!(rnd[0].done && rnd[1].done && rnd[2].done) && w < 95000) begin
      @(negedge clock);
      w++;
    end
    chk("random streams finished", {29'd0, rnd[2].done, rnd[1].done, rnd[0].done}, 32'd7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
